// File: rtl/timer_tick_sched_pkg.sv
// Shared types and control-word bit positions for the four-timer tick scheduler.
package timer_pkg;

  localparam int NUM_TIMERS     = 4;
  localparam int TM_PRESCALE_LO = 0;
  localparam int TM_CASCADE     = 2;
  localparam int TM_IRQ_EN      = 6;
  localparam int TM_START       = 7;

  typedef enum logic [1:0] {
    PRE_1    = 2'd0,
    PRE_64   = 2'd1,
    PRE_256  = 2'd2,
    PRE_1024 = 2'd3
  } prescale_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_e;

  // Last prescale count value before a tick (divide - 1).
  function automatic logic [9:0] div_last(prescale_e p);
    case (p)
      PRE_1:    div_last = 10'd0;
      PRE_64:   div_last = 10'd63;
      PRE_256:  div_last = 10'd255;
      default:  div_last = 10'd1023;
    endcase
  endfunction

endpackage

// File: rtl/timer_tick_sched_prescaler.sv
// One timer's start detect, prescale counter, cascade tick and IRQ pulse; all outputs registered.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] prescale_i,
  input  logic       start_i,
  input  logic       irq_en_i,
  input  logic       cascade_en_i,
  input  logic       ovf_prev_i,
  input  logic       ovf_i,
  output logic       tick_o,
  output logic       reload_o,
  output logic       irq_o
);

  tmr_state_e state_q;
  logic       start_q;
  logic [9:0] cnt_q;
  logic       tick_q, reload_q, irq_q;
  logic       start_rise;
  logic       pre_hit;

  assign start_rise = start_i & ~start_q;
  // >= rather than == so a prescaler shrunk below the running count still wraps.
  assign pre_hit    = (cnt_q >= div_last(prescale_e'(prescale_i)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      reload_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      start_q  <= start_i;
      irq_q    <= ovf_i & irq_en_i;
      tick_q   <= 1'b0;
      reload_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start_rise) begin
            state_q  <= RUN;
            reload_q <= 1'b1;
          end
        end
        RUN: begin
          if (!start_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cascade_en_i) begin
            cnt_q  <= '0;
            tick_q <= ovf_prev_i;
          end else if (pre_hit) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tick_o   = tick_q;
  assign reload_o = reload_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/timer_tick_sched.sv
// Four independent timer tick schedulers; timer x cascades from overflow of timer x-1 (x>0).
module timer_tick_sched
  import timer_pkg::*;
(
  input  logic        clock_16,
  input  logic        reset,
  input  logic [15:0] TM0CNT_H,
  input  logic [15:0] TM1CNT_H,
  input  logic [15:0] TM2CNT_H,
  input  logic [15:0] TM3CNT_H,
  input  logic        overflow0,
  input  logic        overflow1,
  input  logic        overflow2,
  input  logic        overflow3,
  output logic        tick0,
  output logic        tick1,
  output logic        tick2,
  output logic        tick3,
  output logic        reload0,
  output logic        reload1,
  output logic        reload2,
  output logic        reload3,
  output logic        genIRQ0,
  output logic        genIRQ1,
  output logic        genIRQ2,
  output logic        genIRQ3
);

  logic [NUM_TIMERS-1:0][15:0] ctrl;
  logic [NUM_TIMERS-1:0]       ovf, ovf_prev, casc_en;
  logic [NUM_TIMERS-1:0]       tick, reload, irq;

  assign ctrl     = {TM3CNT_H, TM2CNT_H, TM1CNT_H, TM0CNT_H};
  assign ovf      = {overflow3, overflow2, overflow1, overflow0};
  assign ovf_prev = {ovf[NUM_TIMERS-2:0], 1'b0};
  // Timer 0 has no predecessor, so its cascade bit is ignored.
  assign casc_en  = {ctrl[3][TM_CASCADE], ctrl[2][TM_CASCADE], ctrl[1][TM_CASCADE], 1'b0};

  for (genvar x = 0; x < NUM_TIMERS; x++) begin : g_tmr
    timer_prescaler u_tmr (
      .clk_i        (clock_16),
      .rst_i        (reset),
      .prescale_i   (ctrl[x][TM_PRESCALE_LO +: 2]),
      .start_i      (ctrl[x][TM_START]),
      .irq_en_i     (ctrl[x][TM_IRQ_EN]),
      .cascade_en_i (casc_en[x]),
      .ovf_prev_i   (ovf_prev[x]),
      .ovf_i        (ovf[x]),
      .tick_o       (tick[x]),
      .reload_o     (reload[x]),
      .irq_o        (irq[x])
    );
  end

  assign {tick3, tick2, tick1, tick0}         = tick;
  assign {reload3, reload2, reload1, reload0} = reload;
  assign {genIRQ3, genIRQ2, genIRQ1, genIRQ0} = irq;

  logic unused_ctrl;
  assign unused_ctrl = ^{ovf[NUM_TIMERS-1], TM0CNT_H[15:8], TM0CNT_H[5:2],
                         TM1CNT_H[15:8], TM1CNT_H[5:3], TM2CNT_H[15:8], TM2CNT_H[5:3],
                         TM3CNT_H[15:8], TM3CNT_H[5:3]};

endmodule

// File: doc/timer_tick_sched.md
TIMER_TICK_SCHED -- requirements
Module: timer_tick_sched

Interface
REQ-001 The block SHALL have port clock_16, input, 1 bit: the single system clock; all state is on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have ports TM0CNT_H..TM3CNT_H, input, 16 bits each: timer control words. Bits [1:0] select the prescaler, bit 2 selects cascade, bit 6 is IRQ enable and bit 7 is start.
REQ-004 The block SHALL have ports overflow0..overflow3, input, 1 bit each: a one-cycle pulse from each 16-bit counter datapath on wrap from 16'hFFFF.
REQ-005 The block SHALL have ports tick0..tick3, output, 1 bit each: a one-cycle count-enable to each counter.
REQ-006 The block SHALL have ports reload0..reload3, output, 1 bit each: a one-cycle pulse that loads the counter from its reload value.
REQ-007 The block SHALL have ports genIRQ0..genIRQ3, output, 1 bit each: a one-cycle interrupt request pulse.

Function
REQ-008 The block SHALL register start_q[x] = TMxCNT_H[7] every cycle and define start_rise[x] = TMxCNT_H[7] & ~start_q[x].
REQ-009 On start_rise[x] the block SHALL assert reloadx in the next cycle, hold tickx low in that cycle, and clear prescale counter x to 0.
REQ-010 Each timer SHALL use a two-state FSM: IDLE when start=0, RUN when start=1.
- IDLE→RUN on start_rise.
- RUN→IDLE when start falls.
- In IDLE, tickx=0 and the prescale counter is held at 0.
REQ-011 Prescaler divide SHALL be decoded from [1:0] as 00→1, 01→64, 10→256, 11→1024.
REQ-012 The prescale counter SHALL be 10 bits wide and increment each RUN cycle. When counter ≥ divide−1, the block SHALL pulse tickx in the next cycle and wrap the counter to 0.
REQ-013 With divide 1, tickx SHALL be high every cycle after the reloadx cycle.
REQ-014 With divide D, the first tickx SHALL occur exactly D cycles after reloadx, and then every D cycles.
REQ-015 Prescaler changes while in RUN SHALL take effect immediately. The ≥ compare guarantees no missed wrap when D shrinks below the current count.
REQ-016 Cascade (bit 2 = 1) SHALL apply only to timers 1–3.
- Prescale counter held at 0.
- tickx pulses the cycle after overflow(x−1) is high, if in RUN.
- Bit 2 on timer 0 SHALL be ignored, so timer 0 always uses its prescaler.
REQ-017 genIRQx SHALL pulse the cycle after overflowx is high when TMxCNT_H[6]=1, regardless of start. No pulse SHALL occur when bit 6 is 0.
REQ-018 If start_rise[x] and a cascade or prescale tick condition coincide in the same cycle, the reload SHALL win: reloadx=1 and tickx=0 in the next cycle.
REQ-019 If start falls in the same cycle a tick condition is met, tickx SHALL be 0 in the next cycle.
REQ-020 The four timers SHALL operate independently and concurrently. No arbitration SHALL occur; all outputs are registered.

Reset
REQ-021 While reset is high, all outputs SHALL be 0, start_q SHALL be 0, FSMs SHALL be IDLE and prescale counters SHALL be 0.
REQ-022 After reset deasserts with start already 1, the block SHALL treat it as start_rise on the first clock edge and emit reloadx.
REQ-023 Reset asserted mid-count SHALL discard all pending ticks and IRQ pulses.

Structure
REQ-024 A shared package timer_pkg SHALL hold:
- the prescale enum (PRE_1, PRE_64, PRE_256, PRE_1024);
- bit-position constants TM_PRESCALE_LO, TM_CASCADE=2, TM_IRQ_EN=6, TM_START=7;
- the state typedef {IDLE, RUN}.
REQ-025 Per-timer logic SHALL live in one sub-module timer_prescaler, instantiated four times. Instance 0 SHALL have its cascade input tied to 0.

Verification
REQ-026 TM0CNT_H=16'h0080 (start, div 1) → reload0 one cycle later, then tick0 high on every following cycle.
REQ-027 TM1CNT_H=16'h0081 (div 64) → reload1 at cycle 1, tick1 at cycles 65, 129 and 193, and no other ticks.
REQ-028 TM2CNT_H=16'h0084 (cascade) with overflow1 pulsed at cycles 10 and 20 → tick2 at cycles 11 and 21 only. The same with TM0CNT_H bit 2 set → no cascade behaviour on timer 0.
REQ-029 TM3CNT_H=16'h00C3 with overflow3 pulsed → genIRQ3 pulse one cycle later. The same with bit 6 clear → genIRQ3 stays 0.
REQ-030 start_rise on timer 1 coinciding with an overflow0 pulse in cascade mode → reload1=1 and tick1=0. Clearing start during div 256 → no further tick1.
REQ-031 Reset asserted mid-count (div 1024, count 500) → all outputs 0 immediately. Release with start=1 → reload then the first tick 1024 cycles later.
